mtr_drv_pwm: RTL and testbench

MTR_DRV_PWM -- requirements
Module: mtr_drv_pwm

---
 rtl/mtr_drv_pkg.sv | 20 ++
 rtl/pwm_deadband.sv | 79 +++++++
 rtl/mtr_drv_pwm.sv | 47 ++++
 tb/tb_mtr_drv_pwm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the dual H-bridge PWM driver with dead-band insertion.
package mtr_drv_pkg;

  typedef enum logic [1:0] {
    ST_DEAD = 2'd0,
    ST_DRV1 = 2'd1,
    ST_DRV2 = 2'd2
  } pwm_state_e;

  localparam int          DEAD_DEFAULT = 32;
  localparam int          CNT_W        = 11;
  localparam logic [10:0] CNT_MAX      = 11'h7FF;
  localparam logic [10:0] DUTY_RESET   = 11'd1024;

  // Offset-binary view of a two's-complement speed: -1024 -> 0, 0 -> 1024, +1023 -> 2047.
  function automatic logic [10:0] spd_to_duty(input logic [10:0] spd);
    return {~spd[10], spd[9:0]};
  endfunction

endpackage

// File: rtl/pwm_deadband.sv
// One H-bridge channel: period-latched duty, PWM compare and dead-band FSM.
// state   | meaning
// ST_DEAD | both legs off, timing the dead band after a raw edge
// ST_DRV1 | forward leg driven
// ST_DRV2 | reverse leg driven
module pwm_deadband
  import mtr_drv_pkg::*;
#(
  parameter int DEAD = DEAD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              wrap,
  input  logic [CNT_W-1:0]  spd,
  output logic              pwm1,
  output logic              pwm2
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD - 1);

  logic [CNT_W-1:0] duty_q;
  logic             raw;
  logic             last_raw;
  logic [7:0]       dead_cnt;
  pwm_state_e       state;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q   <= DUTY_RESET;
      raw      <= 1'b0;
      last_raw <= 1'b0;
      dead_cnt <= '0;
      state    <= ST_DEAD;
      pwm1     <= 1'b0;
      pwm2     <= 1'b0;
    end else begin
      if (wrap) duty_q <= spd_to_duty(spd);
      raw <= (cnt < duty_q);
      case (state)
        ST_DEAD: begin
          // A raw edge inside the dead band only restarts the timer.
          if (raw != last_raw) begin
            last_raw <= raw;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_LAST) begin
            state <= last_raw ? ST_DRV1 : ST_DRV2;
            pwm1  <= last_raw;
            pwm2  <= ~last_raw;
          end else begin
            dead_cnt <= dead_cnt + 8'd1;
          end
        end
        ST_DRV1: begin
          if (!raw) begin
            state    <= ST_DEAD;
            last_raw <= 1'b0;
            dead_cnt <= '0;
            pwm1     <= 1'b0;
          end
        end
        ST_DRV2: begin
          if (raw) begin
            state    <= ST_DEAD;
            last_raw <= 1'b1;
            dead_cnt <= '0;
            pwm2     <= 1'b0;
          end
        end
        default: begin
          state <= ST_DEAD;
          pwm1  <= 1'b0;
          pwm2  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mtr_drv_pwm.sv
// Dual-wheel PWM motor driver: shared period counter feeding two independent dead-band channels.
module mtr_drv_pwm
  import mtr_drv_pkg::*;
#(
  parameter int DEAD = DEAD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CNT_W-1:0] lft_spd,
  input  logic signed [CNT_W-1:0] rght_spd,
  output logic                    lftPWM1,
  output logic                    lftPWM2,
  output logic                    rghtPWM1,
  output logic                    rghtPWM2
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 11'd1;
  end

  pwm_deadband #(.DEAD(DEAD)) u_lft (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap),
    .spd  (lft_spd),
    .pwm1 (lftPWM1),
    .pwm2 (lftPWM2)
  );

  pwm_deadband #(.DEAD(DEAD)) u_rght (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap),
    .spd  (rght_spd),
    .pwm1 (rghtPWM1),
    .pwm2 (rghtPWM2)
  );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Scoreboard bench for mtr_drv_pwm: point samples and per-period leg high-time statistics.
module tb_mtr_drv_pwm;

  localparam int DEAD = 32;
  localparam int PER  = 2048;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [10:0]  lft_spd = '0;
  logic signed [10:0]  rght_spd = '0;
  logic                lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;

  always #5 clk = ~clk;

  mtr_drv_pwm #(.DEAD(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2)
  );

  typedef struct {
    string      name;
    int         at;
    logic [3:0] exp;
  } pt_t;

  typedef struct {
    string name;
    int    win;
    int    l1, l2, r1, r2, llow;
  } per_t;

  pt_t  pt_q[$];
  per_t per_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int gcount = 0;
  int cyc = 0;
  int rel_g = 0;
  int ovl_total = 0;
  int a_l1, a_l2, a_r1, a_r2, a_llow;

  // Reference period position: mirrors what the shared counter should hold.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pt(input string name, input int at, input logic [3:0] exp);
    pt_t p;
    p.name = name; p.at = at; p.exp = exp;
    pt_q.push_back(p);
  endtask

  task automatic push_per(input string name, input int win, input int l1, input int l2,
                          input int r1, input int r2, input int llow);
    per_t e;
    e.name = name; e.win = win; e.l1 = l1; e.l2 = l2; e.r1 = r1; e.r2 = r2; e.llow = llow;
    per_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [3:0] outs;
    pt_t        p;
    per_t       e;
    a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; a_llow = 0;
    forever begin
      @(posedge clk);
      #1;
      gcount++;
      if (cyc == 0) begin
        a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; a_llow = 0;
      end
      outs = {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2};
      if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) ovl_total++;
      a_l1 += int'(lftPWM1);
      a_l2 += int'(lftPWM2);
      a_r1 += int'(rghtPWM1);
      a_r2 += int'(rghtPWM2);
      a_llow += int'(!lftPWM1 && !lftPWM2);
      while (pt_q.size() > 0 && pt_q[0].at <= gcount) begin
        p = pt_q.pop_front();
        if (p.at < gcount) check({p.name, "_missed"}, gcount, p.at);
        else               check(p.name, int'(outs), int'(p.exp));
      end
      if (cyc % PER == PER - 1) begin
        if (per_q.size() > 0 && per_q[0].win == cyc / PER) begin
          e = per_q.pop_front();
          check({e.name, "_l1_high"}, a_l1, e.l1);
          check({e.name, "_l2_high"}, a_l2, e.l2);
          check({e.name, "_r1_high"}, a_r1, e.r1);
          check({e.name, "_r2_high"}, a_r2, e.r2);
          check({e.name, "_l_both_low"}, a_llow, e.llow);
        end
        a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; a_llow = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    push_pt("rst_outs_low", gcount + 1, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel_g = gcount;
  endtask

  // Period 0 after reset always runs at duty 1024 on both channels.
  task automatic push_startup(input string tag, input bit full);
    push_pt({tag, "_dead_c33"}, rel_g + 33, 4'b0000);
    push_pt({tag, "_drv1_c34"}, rel_g + 34, 4'b1010);
    if (full) begin
      push_pt({tag, "_drv1_c1025"}, rel_g + 1025, 4'b1010);
      push_pt({tag, "_dead_c1026"}, rel_g + 1026, 4'b0000);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("wait_cyc_timeout", cyc, c);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((pt_q.size() > 0 || per_q.size() > 0) && guard < 12000) begin
      @(negedge clk);
      guard++;
    end
    while (pt_q.size() > 0) begin
      pt_t p = pt_q.pop_front();
      check({p.name, "_never_sampled"}, gcount, p.at);
    end
    while (per_q.size() > 0) begin
      per_t e = per_q.pop_front();
      check({e.name, "_window_never_seen"}, cyc / PER, e.win);
    end
  endtask

  initial begin
    // Both channels at zero speed: symmetric 992/992 legs, 64 dead clocks per period.
    lft_spd = 11'sd0; rght_spd = 11'sd0;
    do_reset();
    push_startup("a", 1'b1);
    for (int w = 1; w <= 3; w++) push_per($sformatf("a_w%0d", w), w, 992, 992, 992, 992, 64);
    wait_drain();

    // Full reverse left, full forward right; new duties take effect from period 1.
    @(negedge clk);
    lft_spd = -11'sd1024; rght_spd = 11'sd1023;
    do_reset();
    push_startup("b", 1'b1);
    push_per("b_w1", 1, 0, 2048, 2014, 2, 0);
    push_per("b_w2", 2, 0, 2048, 2015, 0, 0);
    push_per("b_w3", 3, 0, 2048, 2015, 0, 0);
    wait_drain();

    // Speed change mid-period waits for the next wrap.
    @(negedge clk);
    lft_spd = 11'sd0; rght_spd = 11'sd0;
    do_reset();
    push_startup("c", 1'b1);
    push_per("c_w1", 1, 992, 992, 992, 992, 64);
    wait_cyc(PER + 500);
    lft_spd = 11'sd512;
    push_per("c_w2", 2, 1504, 480, 992, 992, 64);
    push_per("c_w3", 3, 1504, 480, 992, 992, 64);
    wait_drain();

    // Reset while the forward leg is driven at cnt 300.
    @(negedge clk);
    lft_spd = 11'sd0; rght_spd = 11'sd0;
    do_reset();
    push_startup("d", 1'b0);
    wait_cyc(299);
    push_pt("d_drv1_c300", gcount + 1, 4'b1010);
    @(negedge clk);
    rst = 1'b1;
    push_pt("d_rst_outs_low", gcount + 1, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    rel_g = gcount;
    push_startup("d2", 1'b1);
    push_per("d2_w1", 1, 992, 992, 992, 992, 64);
    wait_drain();

    check("overlap_cycles", ovl_total, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
